// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: reset PC default,
// instruction width, fetch state encodings and the prefetch entry layout.
package inst_fetch_unit_pkg;

   localparam int          INST_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0] data;
      logic [31:0]       pc;
   } fetch_entry_t;

   // Clear the byte offset so every fetch address is a word address
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO used both for the request PC tags and for the
// prefetched {data, pc} entries. Flush empties it in one cycle and takes
// priority over a push or pop in the same cycle. Depth must be a power of two.
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter int  WIDTH = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Storage and pointers; cleared to zero so the head reads 0 out of reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Pointer/count update; a simultaneous push and pop leaves the count alone
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words in a prefetch FIFO and hands
// them to the datapath. Redirects flush the buffer and discard stale
// in-flight responses.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds the fetch_misalign
// output, which latches on a non word-aligned redirect target and halts fetch.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [31:0]       imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [31:0]       inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic              fetch_misalign
`endif
);

   localparam int             CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             fetch_en_q, fetch_en_d;
   logic             misalign_q, misalign_d;

   logic             misalign_hit;
   logic             req_fire;
   logic             rsp_take;
   logic             rsp_push;
   logic             inst_pop;
   logic [CNT_W:0]   slots_used;
   logic [CNT_W-1:0] tag_count;
   logic [CNT_W-1:0] data_count;
   logic [31:0]      tag_head;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign_hit   = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign fetch_misalign = misalign_q;
`else
   assign misalign_hit   = 1'b0;
`endif

   // A response only counts when something is really in flight; anything
   // arriving with nothing outstanding (e.g. just after reset) is ignored.
   assign req_fire   = imem_req_valid && imem_req_ready;
   assign rsp_take   = imem_rsp_valid && (outstanding_q != '0);
   assign rsp_push   = rsp_take && (drop_cnt_q == '0) && !redirect_valid && (tag_count != '0);
   assign inst_valid = (data_count != '0);
   assign inst_pop   = inst_valid && inst_ready;

   // The slot freed by this cycle's pop is credited immediately, so a
   // two-entry buffer sustains one instruction per cycle with 1-cycle memory.
   assign slots_used = {1'b0, outstanding_q} + {1'b0, data_count} - {{CNT_W{1'b0}}, inst_pop};

   // Fetch state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // PC, in-flight bookkeeping, fetch enable and the sticky misalign flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         fetch_en_q    <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         fetch_en_q    <= fetch_en_d;
         misalign_q    <= misalign_d;
      end
   end

   // Next state: a redirect enters FLUSH only while stale responses remain
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = (drop_cnt_d != '0) ? FLUSH : FETCH;
      end else if ((state_q == FLUSH) && (drop_cnt_d == '0)) begin
         state_d = FETCH;
      end
   end

   // Request issue: only in FETCH, never on a redirect cycle, and only with
   // a free buffer slot reserved for the returning word
   always_comb begin
      imem_req_valid = 1'b0;
      if ((state_q == FETCH) && fetch_en_q && !misalign_q && !redirect_valid
          && (slots_used < DEPTH_LIM)) begin
         imem_req_valid = 1'b1;
      end
   end

   // PC advance and outstanding/drop counters; a redirect turns everything
   // still in flight (less a response dropped this cycle) into drops
   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      fetch_en_d    = 1'b1;
      misalign_d    = misalign_q | misalign_hit;
      if (req_fire) begin
         pc_d          = pc_q + PC_STEP;
         outstanding_d = outstanding_q + CNT_ONE;
      end
      if (rsp_take) begin
         outstanding_d = outstanding_d - CNT_ONE;
      end
      if (redirect_valid) begin
         pc_d       = word_align(redirect_pc);
         drop_cnt_d = outstanding_d;
      end else if (rsp_take && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CNT_ONE;
      end
   end

   assign imem_req_addr = pc_q;
   assign push_entry    = '{data: imem_rsp_data, pc: tag_head};
   assign inst_data     = inst_valid ? head_entry.data : '0;
   assign inst_pc       = inst_valid ? head_entry.pc : '0;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (pc_q),
      .pop       (rsp_push),
      .head_data (tag_head),
      .count     (tag_count)
   );

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_data_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_push),
      .push_data (push_entry),
      .pop       (inst_pop),
      .head_data (head_entry),
      .count     (data_count)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a behavioural
// in-order instruction memory of configurable latency.
module tb_inst_fetch_unit;
   import inst_fetch_unit_pkg::*;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misalign;
`endif

   int          nChecks = 0;
   int          nFails  = 0;
   int          cyc     = 0;
   int          memLat  = 1;
   mreq_t       memq[$];
   logic [31:0] reqAddr[$];
   int          reqCyc[$];
   logic [31:0] gotPc[$];
   logic [31:0] gotData[$];
   int          gotCyc[$];
   logic        lastReqValid;
   logic [31:0] lastReqAddr;
   logic        lastPop;
   int          k;

   inst_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   // Memory word contents as a function of address
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return {addr[15:0], ~addr[15:0]};
   endfunction

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs and memory response, sample at negedge,
   // log accepted requests and consumed instructions
   task automatic applyStimulus(input logic memReady, input logic rdy,
                                input logic redir, input logic [31:0] rpc);
      mreq_t m;
      imem_req_ready = memReady;
      inst_ready     = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (memq.size() != 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memWord(memq[0].addr);
         memq.delete(0);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      lastReqValid = imem_req_valid;
      lastReqAddr  = imem_req_addr;
      lastPop      = inst_valid && inst_ready;
      if (imem_req_valid && imem_req_ready) begin
         m.addr = imem_req_addr;
         m.due  = cyc + memLat;
         memq.push_back(m);
         reqAddr.push_back(imem_req_addr);
         reqCyc.push_back(cyc);
      end
      if (lastPop) begin
         gotPc.push_back(inst_pc);
         gotData.push_back(inst_data);
         gotCyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      redirect_valid = 1'b0;
   endtask

   task automatic clearLogs();
      reqAddr.delete();
      reqCyc.delete();
      gotPc.delete();
      gotData.delete();
      gotCyc.delete();
   endtask

   task automatic doReset();
      rst = 1'b0;
      memq.delete();
      clearLogs();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
   endtask

   task automatic runUntilReq(input int n, input logic rdy, input int budget);
      int b = 0;
      while (reqAddr.size() < n && b < budget) begin
         applyStimulus(1'b1, rdy, 1'b0, 32'h0);
         b++;
      end
      checkOutput("req_wait", 32'(reqAddr.size() >= n), 32'd1);
   endtask

   task automatic runUntilGot(input int n, input int budget);
      int b = 0;
      while (gotPc.size() < n && b < budget) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
         b++;
      end
      checkOutput("got_wait", 32'(gotPc.size() >= n), 32'd1);
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_req_addr", imem_req_addr, 32'h0000_0000);
      checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_inst_data", inst_data, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      checkOutput("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
      @(posedge clk);
      #1;

      // Streaming with single-cycle memory and an always-ready consumer
      memLat = 1;
      doReset();
      for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("stream_first_addr", reqAddr[0], 32'h0000_0000);
      checkOutput("stream_latency", 32'(gotCyc[0] - reqCyc[0]), 32'd2);
      for (int i = 0; i < 8; i++) begin
         checkOutput("stream_pc", gotPc[i], 32'(4 * i));
         checkOutput("stream_data", gotData[i], memWord(32'(4 * i)));
      end
      for (int i = 0; i < 7; i++) begin
         checkOutput("stream_b2b", 32'(gotCyc[i+1] - gotCyc[i]), 32'd1);
      end

      // Stalled consumer: exactly FIFO_DEPTH requests, nothing lost on resume
      doReset();
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_req_count", 32'(reqAddr.size()), 32'd2);
      checkOutput("stall_req_valid", 32'(lastReqValid), 32'd0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("resume_pc0", gotPc[0], 32'h0);
      checkOutput("resume_pc1", gotPc[1], 32'h4);
      checkOutput("resume_pc2", gotPc[2], 32'h8);
      checkOutput("resume_pc3", gotPc[3], 32'hC);
      checkOutput("resume_data1", gotData[1], memWord(32'h4));

      // Redirect with two requests outstanding on a 3-cycle memory
      memLat = 3;
      doReset();
      runUntilReq(2, 1'b1, 10);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      checkOutput("redir_state0", 32'(dut.state_q), 32'(FLUSH));
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("flush_req0", 32'(lastReqValid), 32'd0);
      checkOutput("redir_state1", 32'(dut.state_q), 32'(FLUSH));
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("flush_req1", 32'(lastReqValid), 32'd0);
      checkOutput("redir_state2", 32'(dut.state_q), 32'(FETCH));
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("redir_req_valid", 32'(lastReqValid), 32'd1);
      checkOutput("redir_req_addr", lastReqAddr, 32'h0000_0100);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("redir_pc0", gotPc[0], 32'h0000_0100);
      checkOutput("redir_data0", gotData[0], memWord(32'h0000_0100));
      checkOutput("redir_pc1", gotPc[1], 32'h0000_0104);

      // Redirect coinciding with a response and a consume
      memLat = 1;
      doReset();
      runUntilGot(4, 20);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      checkOutput("coinc_pop", 32'(lastPop), 32'd1);
      checkOutput("coinc_kept_pc", gotPc[gotPc.size()-1], 32'h0000_0010);
      k = gotPc.size();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("coinc_req_valid", 32'(lastReqValid), 32'd1);
      checkOutput("coinc_req_addr", lastReqAddr, 32'h0000_0200);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("coinc_next_pc", gotPc[k], 32'h0000_0200);
      checkOutput("coinc_next_pc1", gotPc[k+1], 32'h0000_0204);

      // Asynchronous reset mid-stream with two outstanding requests
      memLat = 3;
      doReset();
      runUntilReq(2, 1'b1, 10);
      checkOutput("pre_rst_addr", imem_req_addr, 32'h0000_0008);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("mid_rst_addr", imem_req_addr, 32'h0000_0000);
      checkOutput("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
      checkOutput("mid_rst_inst_pc", inst_pc, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      clearLogs();
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("post_rst_req0", reqAddr[0], 32'h0000_0000);
      checkOutput("post_rst_pc0", gotPc[0], 32'h0000_0000);
      checkOutput("post_rst_data0", gotData[0], memWord(32'h0));
      checkOutput("post_rst_pc1", gotPc[1], 32'h0000_0004);

      // Non word-aligned redirect target
      memLat = 1;
      doReset();
      runUntilGot(2, 20);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
      checkOutput("misalign_set", 32'(fetch_misalign), 32'd1);
      clearLogs();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("misalign_no_req", 32'(reqAddr.size()), 32'd0);
      checkOutput("misalign_sticky", 32'(fetch_misalign), 32'd1);
`else
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("align_req_valid", 32'(lastReqValid), 32'd1);
      checkOutput("align_req_addr", lastReqAddr, 32'h0000_0100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front end for Yu Core, directly upstream of `DataPath`. Owns the program counter and issues in-order word requests to instruction memory over a valid/ready request channel. Buffers returned words in a small prefetch FIFO and presents them to the datapath with a valid/ready handshake. Handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `FIFO_DEPTH`, 2, prefetch entries; power of two, 2..8.
- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response word valid; in order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  datapath redirect (taken branch/jump), single-cycle pulse.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  `inst_data`/`inst_pc` valid.
- `inst_ready`  in  1  datapath consumes head instruction.
- `inst_data`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst_data`.
- `fetch_misalign`  out  1  present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- Registers: `pc`, `outstanding` (accepted, unreturned requests), `drop_cnt` (stale responses to discard), FIFO entries {data, pc}, state.
- Credit rule: `imem_req_valid` = state FETCH && !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH. Never overflows FIFO.
- Request accepted (valid && ready): `pc <= pc + 4`, outstanding++; request's PC travels with it via a PC-tag FIFO of same depth.
- Response: if drop_cnt > 0, discard and drop_cnt--; else push {data, tagged pc}. outstanding-- either way.
- Consumption: `inst_valid && inst_ready` pops head.
- States: FETCH (normal); FLUSH (waiting for stale responses).
- Redirect in cycle N: FIFO and PC tags cleared; `pc <= redirect_pc`; drop_cnt <= outstanding (minus one if a response arrives in cycle N, which is itself discarded); outstanding set accordingly. Next state FLUSH if resulting drop_cnt > 0, else FETCH.
- FLUSH -> FETCH when drop_cnt reaches 0; no requests issued in FLUSH.
- Redirect coinciding with an `inst_valid && inst_ready` handshake: handshake counts (that instruction is the branch itself); remaining entries flushed.
- Redirect in FLUSH: reload pc, drop_cnt unchanged semantics (recomputed from outstanding).
- Simultaneous push and pop with full FIFO: legal only via credit rule; count unchanged.
- `pc` wraps modulo 2^32.

## Timing
- Reset values: `imem_req_valid` 0, `imem_req_addr` RESET_PC, `inst_valid` 0, `inst_data` 0, `inst_pc` 0, `fetch_misalign` 0, state FETCH, counters 0.
- First request: cycle after `rst` deasserts (address RESET_PC).
- Response accepted into FIFO at edge of `imem_rsp_valid` cycle; `inst_valid` next cycle (1-cycle registered latency, no bypass).
- Redirect-to-request: redirect cycle N, new request cycle N+1 if no stale responses.
- Sustained throughput: 1 instruction/cycle with single-cycle memory and FIFO_DEPTH ≥ 2.
- Reset mid-operation: all state cleared immediately (async); responses arriving after reset release with outstanding=0 are ignored.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: `redirect_pc[1:0] != 0` sets `fetch_misalign` (sticky until reset), blocks further requests, FIFO drained normally.
- Undefined: port absent; `redirect_pc[1:0]` forced to 0.

## Structure
- Shared package/header (`Parameters.vh`): `RESET_PC` default, instruction width 32, state encodings FETCH/FLUSH.
- One sub-module: `fetch_fifo` (synchronous FIFO, depth parameter, flush input, count output), instantiated for data+PC.

## Test plan
- Reset release, memory always ready, 1-cycle response, inst_ready=1 -> inst_pc 0x0,0x4,0x8... on consecutive cycles from cycle 2.
- inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then `imem_req_valid`=0; no word lost on resume.
- Redirect to 0x100 with 2 requests outstanding -> both responses dropped, state FLUSH 2 cycles, next inst_pc 0x100.
- Redirect with simultaneous response and consume -> consumed word kept, arriving word dropped, next inst_pc = target.
- `rst` asserted mid-stream with 2 outstanding -> outputs at reset values immediately; first post-release inst_pc = RESET_PC.
- With `FETCH_MISALIGN_CHECK_EN`, redirect_pc 0x102 -> `fetch_misalign`=1 next cycle, no further requests.
